// File: rtl/acq_sequencer.sv
// Acquisition sequencer: orders DAC start, a frame-counted start delay and a
// bounded or continuous ADC capture window, with sticky DAC-underrun reporting.
module acq_sequencer #(
  parameter int CNT_W = 32,
  parameter int DLY_W = 16
) (
  input  logic             capture_clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             cfg_wait_dac,
  input  logic [DLY_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_frames,
  input  logic             frame_tick,
  input  logic             dac_empty,
  input  logic             capture_full,
  output logic             dac_run,
  output logic             adc_run,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic             underrun,
  output logic [CNT_W-1:0] frame_count,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_DAC = 3'd1,
    ST_DELAY    = 3'd2,
    ST_RUN      = 3'd3,
    ST_DONE     = 3'd4,
    ST_FAULT    = 3'd5
  } state_t;

  localparam logic [DLY_W-1:0] DLY_ZERO = {DLY_W{1'b0}};
  localparam logic [DLY_W-1:0] DLY_ONE  = {{(DLY_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_s;
  logic [DLY_W-1:0] dly_r, dly_s;
  logic [CNT_W-1:0] frames_r, frames_s;
  logic [CNT_W-1:0] count_s;
  logic             underrun_s;
  logic             starved_s;

  // Next-state, latched configuration and counter updates.
  always_comb begin
    state_s    = state_r;
    dly_s      = dly_r;
    frames_s   = frames_r;
    count_s    = frame_count;
    starved_s  = frame_tick & dac_empty &
                 ((state_r == ST_DELAY) | (state_r == ST_RUN));
    // A starved tick on the same edge as clear keeps the flag set.
    underrun_s = starved_s | (underrun & ~clear);

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          dly_s    = cfg_delay;
          frames_s = cfg_frames;
          count_s  = CNT_ZERO;
          state_s  = cfg_wait_dac ? ST_WAIT_DAC : ST_DELAY;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT_DAC: begin
        if (stop) begin
          state_s = ST_IDLE;
        end else if (!dac_empty) begin
          state_s = ST_DELAY;
        end else begin
          state_s = ST_WAIT_DAC;
        end
      end
      ST_DELAY: begin
        if (stop) begin
          state_s = ST_IDLE;
        end else if (dly_r == DLY_ZERO) begin
          state_s = ST_RUN;
        end else if (frame_tick) begin
          dly_s   = dly_r - DLY_ONE;
          state_s = (dly_r == DLY_ONE) ? ST_RUN : ST_DELAY;
        end else begin
          state_s = ST_DELAY;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_s = ST_IDLE;
        end else if (capture_full) begin
          state_s = ST_FAULT;
        end else if (frame_tick) begin
          count_s = frame_count + CNT_ONE;
          if ((frames_r != CNT_ZERO) && (count_s == frames_r)) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_s = clear ? ST_IDLE : ST_DONE;
      end
      ST_FAULT: begin
        state_s = clear ? ST_IDLE : ST_FAULT;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and all outputs registered from the next state.
  always_ff @(posedge capture_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      dly_r       <= DLY_ZERO;
      frames_r    <= CNT_ZERO;
      frame_count <= CNT_ZERO;
      underrun    <= 1'b0;
      state       <= 3'd0;
      dac_run     <= 1'b0;
      adc_run     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state_r     <= state_s;
      dly_r       <= dly_s;
      frames_r    <= frames_s;
      frame_count <= count_s;
      underrun    <= underrun_s;
      state       <= state_s;
      dac_run     <= (state_s == ST_DELAY) | (state_s == ST_RUN);
      adc_run     <= (state_s == ST_RUN);
      busy        <= (state_s == ST_WAIT_DAC) | (state_s == ST_DELAY) |
                     (state_s == ST_RUN);
      done        <= (state_s == ST_DONE);
      fault       <= (state_s == ST_FAULT);
    end
  end

endmodule
